// File: rtl/red_acc.sv
// Iterative signed lane-reduction unit: sums 2*LANES signed lanes, one lane pair
// per clock, into an OUT_W-bit result with optional running accumulation.
module red_acc #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4,
  parameter int OUT_W  = 16,
  parameter bit SAT    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*LANE_W-1:0]  A,
  input  logic [LANES*LANE_W-1:0]  B,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         R,
  output logic                     ovf
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [OUT_W-1:0] SUM_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SUM_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

  state_t                    state;
  logic [LANES*LANE_W-1:0]   a_reg;
  logic [LANES*LANE_W-1:0]   b_reg;
  logic [IDX_W-1:0]          idx;
  logic [OUT_W-1:0]          acc;

  logic [LANE_W-1:0]         a_lane [LANES];
  logic [LANE_W-1:0]         b_lane [LANES];
  logic [LANE_W-1:0]         a_cur;
  logic [LANE_W-1:0]         b_cur;
  logic [OUT_W:0]            wide;
  logic                      step_ovf;
  logic [OUT_W-1:0]          step_val;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign a_lane[gi] = a_reg[gi*LANE_W +: LANE_W];
      assign b_lane[gi] = b_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign a_cur = a_lane[idx];
  assign b_cur = b_lane[idx];

  // One extra bit of headroom: the top two bits disagree exactly on signed overflow.
  assign wide = {R[OUT_W-1], R}
              + {{(OUT_W+1-LANE_W){a_cur[LANE_W-1]}}, a_cur}
              + {{(OUT_W+1-LANE_W){b_cur[LANE_W-1]}}, b_cur};
  assign step_ovf = wide[OUT_W] ^ wide[OUT_W-1];

  always_comb begin
    step_val = wide[OUT_W-1:0];
    if (SAT && step_ovf) begin
      step_val = wide[OUT_W] ? SUM_MIN : SUM_MAX;
    end
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      R         <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) begin
            acc <= '0;
          end
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            // A coincident clear beats acc_en: the transaction starts from zero.
            R     <= (acc_en && !acc_clr) ? acc : '0;
            ovf   <= 1'b0;
            idx   <= '0;
            state <= SUM;
          end
        end
        SUM: begin
          R   <= step_val;
          ovf <= ovf | step_ovf;
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            acc       <= R;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_acc.sv
// Bench for red_acc: three instances (16-bit wrap, 8-bit wrap, 8-bit saturate) share
// one stimulus stream and are checked every cycle against a transaction-level model.
module tb_red_acc;
  localparam int LW = 4;
  localparam int LN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        acc_en = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic        rdy16, rdy8w, rdy8s;
  logic        ov16, ov8w, ov8s;
  logic [15:0] r16;
  logic [7:0]  r8w, r8s;
  logic        f16, f8w, f8s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  red_acc #(.LANE_W(LW), .LANES(LN), .OUT_W(16), .SAT(1'b0)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .A(A), .B(B),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov16), .out_ready(out_ready),
    .R(r16), .ovf(f16));
  red_acc #(.LANE_W(LW), .LANES(LN), .OUT_W(8), .SAT(1'b0)) u8w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8w), .A(A), .B(B),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov8w), .out_ready(out_ready),
    .R(r8w), .ovf(f8w));
  red_acc #(.LANE_W(LW), .LANES(LN), .OUT_W(8), .SAT(1'b1)) u8s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8s), .A(A), .B(B),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov8s), .out_ready(out_ready),
    .R(r8s), .ovf(f8s));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-transaction reference: integer sum of all lanes with per-step range handling.
  // Returns {ovf, value as 32-bit signed int}.
  function automatic logic [32:0] red_model(input int start, input logic [15:0] a,
                                            input logic [15:0] b, input int w, input bit sat);
    int s;
    int mx;
    int mn;
    bit o;
    s  = start;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    o  = 1'b0;
    for (int i = 0; i < LN; i++) begin
      s = s + int'($signed(a[i*LW +: LW])) + int'($signed(b[i*LW +: LW]));
      if (s > mx) begin
        o = 1'b1;
        s = sat ? mx : s - (1 << w);
      end else if (s < mn) begin
        o = 1'b1;
        s = sat ? mn : s + (1 << w);
      end
    end
    return {o, s};
  endfunction

  int          width_of [3] = '{16, 8, 8};
  bit          sat_of   [3] = '{1'b0, 1'b0, 1'b1};
  int          m_acc    [3] = '{0, 0, 0};
  logic [32:0] m_res    [3] = '{33'd0, 33'd0, 33'd0};
  int          phase = 0;  // 0 idle, 1 busy, 2 result pending
  int          cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      phase <= 0;
      cnt   <= 0;
      m_acc <= '{0, 0, 0};
    end else begin
      case (phase)
        0: begin
          if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
              m_res[k] <= red_model((acc_en && !acc_clr) ? m_acc[k] : 0, A, B,
                                    width_of[k], sat_of[k]);
            end
            phase <= 1;
            cnt   <= 0;
          end
          if (acc_clr) m_acc <= '{0, 0, 0};
        end
        1: begin
          cnt <= cnt + 1;
          if (cnt + 1 == LN) phase <= 2;
        end
        default: begin
          if (out_ready) begin
            for (int k = 0; k < 3; k++) m_acc[k] <= int'(m_res[k][31:0]);
            phase <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready16", rdy16, (phase == 0) && !rst);
    check("in_ready8w", rdy8w, (phase == 0) && !rst);
    check("in_ready8s", rdy8s, (phase == 0) && !rst);
    check("out_valid16", ov16, phase == 2);
    check("out_valid8w", ov8w, phase == 2);
    check("out_valid8s", ov8s, phase == 2);
    if (phase == 2) begin
      check("R16", r16, m_res[0][15:0]);
      check("R8w", r8w, m_res[1][7:0]);
      check("R8s", r8s, m_res[2][7:0]);
      check("ovf16", f16, m_res[0][32]);
      check("ovf8w", f8w, m_res[1][32]);
      check("ovf8s", f8s, m_res[2][32]);
    end
  end

  logic [15:0] res16;
  logic [7:0]  res8w, res8s;
  logic [2:0]  resf;
  int          lat;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  task automatic txn(input logic [15:0] a, input logic [15:0] b, input bit en, input bit clr,
                     input int hold, input bit clr_mid);
    int n;
    n = 0;
    while (!rdy16 && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_accept", rdy16, 1'b1);
    A = a; B = b; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
    lat = 1;
    if (clr_mid) begin
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      lat++;
    end
    while (!ov16 && lat < 20) begin
      tick();
      lat++;
    end
    res16 = r16; res8w = r8w; res8s = r8s; resf = {f16, f8w, f8s};
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      A = A ^ 16'hA5C3;
      tick();
      check("bp_R_stable", r16, res16);
      check("bp_ovf_stable", {f16, f8w, f8s}, resf);
      check("bp_in_ready_low", rdy16, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_after_handshake", rdy16, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    check("rst_in_ready", rdy16, 1'b0);
    check("rst_out_valid", ov16, 1'b0);
    check("rst_R", r16, 16'h0000);
    check("rst_ovf", f16, 1'b0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", rdy16, 1'b1);

    txn(16'h7777, 16'h7777, 1'b0, 1'b0, 0, 1'b0);
    $display("txn 7777+7777: R16=%h ovf=%b lat=%0d", res16, resf[2], lat);
    check("lit_7777_R", res16, 16'h0038);
    check("lit_7777_ovf", resf[2], 1'b0);
    check("lit_latency", lat, LN + 1);

    txn(16'h8888, 16'h8888, 1'b0, 1'b0, 0, 1'b0);
    $display("txn 8888+8888: R16=%h R8w=%h", res16, res8w);
    check("lit_8888_R", res16, 16'hFFC0);
    check("lit_8888_R8", res8w, 8'hC0);

    txn(16'h1234, 16'hF0F0, 1'b0, 1'b0, 5, 1'b0);
    $display("txn 1234+F0F0 with backpressure: R16=%h ovf=%b", res16, resf[2]);
    check("lit_mixed_R", res16, 16'h0008);
    check("lit_mixed_ovf", resf[2], 1'b0);

    pulse_clr();
    txn(16'h7777, 16'h7777, 1'b1, 1'b0, 0, 1'b0);
    $display("acc txn1: R8w=%h R8s=%h", res8w, res8s);
    check("lit_acc1_R8w", res8w, 8'h38);
    txn(16'h7777, 16'h7777, 1'b1, 1'b0, 1, 1'b0);
    $display("acc txn2: R8w=%h R8s=%h", res8w, res8s);
    check("lit_acc2_R8w", res8w, 8'h70);
    check("lit_acc2_ovf8w", resf[1], 1'b0);
    txn(16'h7777, 16'h7777, 1'b1, 1'b0, 0, 1'b0);
    $display("acc txn3: R16=%h R8w=%h ovf8w=%b R8s=%h ovf8s=%b",
             res16, res8w, resf[1], res8s, resf[0]);
    check("lit_acc3_R16", res16, 16'h00A8);
    check("lit_acc3_R8w", res8w, 8'hA8);
    check("lit_acc3_ovf8w", resf[1], 1'b1);
    check("lit_acc3_R8s", res8s, 8'h7F);
    check("lit_acc3_ovf8s", resf[0], 1'b1);

    pulse_clr();
    txn(16'h7777, 16'h7777, 1'b0, 1'b0, 0, 1'b0);
    $display("seed acc: R16=%h", res16);
    txn(16'h1111, 16'h1111, 1'b1, 1'b1, 0, 1'b0);
    $display("clr with accept: R16=%h", res16);
    check("lit_clr_priority", res16, 16'h0008);
    txn(16'h1111, 16'h1111, 1'b1, 1'b0, 0, 1'b1);
    $display("clr during SUM: R16=%h", res16);
    check("lit_clr_mid_ignored", res16, 16'h0010);

    A = 16'h7777; B = 16'h7777; acc_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_in_ready", rdy16, 1'b0);
    check("midrst_out_valid", ov16, 1'b0);
    rst = 1'b0;
    tick();
    $display("reset mid-SUM: in_ready=%b out_valid=%b", rdy16, ov16);
    check("midrst_ready_after", rdy16, 1'b1);
    check("midrst_no_result", ov16, 1'b0);
    txn(16'h7777, 16'h7777, 1'b1, 1'b0, 0, 1'b0);
    $display("after reset acc txn: R16=%h", res16);
    check("lit_after_rst_acc", res16, 16'h0038);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/red_acc.md
# red_acc

Parametrised, multi-cycle signed lane-reduction unit with optional running accumulation. It is the successor to the fixed 4×4-bit RED path. It accepts two packed vectors of `LANES` signed lanes of `LANE_W` bits each, sums all 2·`LANES` lanes (one lane pair per clock), and returns a sign-extended `OUT_W`-bit result over a valid/ready handshake. It sits beside the ALU as an iterative execution resource, with wrap or saturate overflow handling and a sticky-across-steps overflow flag.

## Interface
- `LANE_W`, 4, width of one signed lane (≥2)
- `LANES`, 4, lanes per operand vector (≥1)
- `OUT_W`, 16, result/accumulator width (≥ `LANE_W`+1)
- `SAT`, 0, overflow handling: 0 = two's-complement wrap, 1 = clamp to signed max/min at every step
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand vector present
- `in_ready`  out  1  unit can accept (IDLE state)
- `A`  in  LANES·LANE_W  lane i = `A[i·LANE_W +: LANE_W]`, signed
- `B`  in  LANES·LANE_W  same packing as `A`
- `acc_en`  in  1  sampled at accept: 1 = start from accumulator, 0 = start from 0
- `acc_clr`  in  1  clear accumulator (honoured only in IDLE)
- `out_valid`  out  1  `R`/`ovf` valid
- `out_ready`  in  1  consumer takes result
- `R`  out  OUT_W  signed result
- `ovf`  out  1  signed overflow occurred in any step of this transaction

## Operation
- States: IDLE, SUM, DONE. `in_ready` = (state==IDLE) && !rst.
- IDLE: on `in_valid`, capture `A`, `B`. Load sum register with the accumulator if `acc_en`, else 0. Set lane index to 0, clear the `ovf` working bit, go to SUM.
- SUM: each clock, sum ← sum + sext(A lane i) + sext(B lane i), computed at OUT_W+1 bits.
  - Signed overflow: the OUT_W+1 result does not fit in OUT_W. On overflow, the working `ovf` bit is set.
  - SAT=0 keeps the low OUT_W bits. SAT=1 clamps to 2^(OUT_W−1)−1 or −2^(OUT_W−1), and later steps continue from the clamped value.
  - After lane `LANES`−1 the unit goes to DONE.
- DONE: `out_valid`=1; `R` and `ovf` are held stable. On `out_ready`, accumulator ← `R`, go to IDLE.
- `acc_clr` in IDLE sets the accumulator to 0 at that edge. If it coincides with an accept that has `acc_en`=1, the clear wins: start value = 0.
- `acc_clr` outside IDLE is ignored. The accumulator is updated only at a DONE handshake, never mid-transaction.
- `in_valid` is ignored in SUM and DONE. `out_ready` is ignored outside DONE.

## Timing
- Reset (rst=1 at an edge) sets: state IDLE, `out_valid`=0, `R`=0, `ovf`=0, accumulator=0, lane index=0. `in_ready`=0 while rst is high and 1 in the first cycle after.
- Reset mid-SUM or in DONE abandons the transaction; no result is emitted.
- Accept edge E0. Lane pairs are added at edges E1..E_LANES. `out_valid` is high from the cycle after E_LANES, giving a latency of `LANES` cycles (4 at defaults).
- Handshake at edge H (out_valid & out_ready): `out_valid`=0 and `in_ready`=1 in the next cycle. The earliest next accept is edge H+1.
- Minimum initiation interval is `LANES`+2 cycles. There is no overlap between transactions.
- `R`/`ovf` are registered outputs and do not change while `out_valid`=1 && !`out_ready`.

## Test plan
- Defaults, acc_en=0: A=0x7777, B=0x7777 → R=0x0038, ovf=0, `out_valid` rises 4 cycles after accept. A=0x8888, B=0x8888 → R=0xFFC0.
- Mixed signs: A=0x1234, B=0xF0F0 → R=0x0008, ovf=0.
- Accumulate, OUT_W=8, SAT=0: three transactions of A=B=0x7777 with acc_en=1 after acc_clr → R=0x38, 0x70, then 0xA8 with ovf=1. With SAT=1 the third → R=0x7F, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/A → R, ovf stable, in_ready=0, no accept. Release → in_ready=1 the next cycle.
- acc_clr priority: accumulator=0x38, then acc_clr=1 with an accept of A=B=0x1111, acc_en=1 → R=0x0008. acc_clr pulsed during SUM → accumulator unaffected.
- Reset mid-SUM (edge E2) → out_valid stays 0, accumulator=0, in_ready=1 the cycle after rst drops. The next transaction with A=B=0x7777, acc_en=1 → R=0x0038.
